// File: rtl/pool_sequencer.sv
// 2x2 / stride-2 max-pool sequencer: reads four pixels per pooled output, writes the max back in place.
// Optional build macro POOL_RELU_EN fuses a ReLU clamp into the write-back.
module pool_sequencer #(
  parameter int H  = 28,
  parameter int W  = 28,
  parameter int DW = 8,
  parameter int AW = 10
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic          o_rd_en,
  output logic [AW-1:0] o_rd_addr,
  input  logic [DW-1:0] i_rd_data,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [DW-1:0] o_wr_data,
  output logic          o_busy,
  output logic          o_done
);

  // state  | meaning
  // IDLE   | waiting for start
  // R0..R3 | read the four input pixels of the current 2x2 window
  // LAST   | fold the R3 read data into the running max
  // WR     | write the pooled value, advance pr/pc
  // DONE   | one-cycle done pulse, counters cleared
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_R0   = 3'd1;
  localparam logic [2:0] S_R1   = 3'd2;
  localparam logic [2:0] S_R2   = 3'd3;
  localparam logic [2:0] S_R3   = 3'd4;
  localparam logic [2:0] S_LAST = 3'd5;
  localparam logic [2:0] S_WR   = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  localparam logic [AW-1:0] LP_PC_LAST = AW'(W / 2 - 1);
  localparam logic [AW-1:0] LP_PR_LAST = AW'(H / 2 - 1);
  localparam logic [AW-1:0] LP_ROW2    = AW'(2 * W);
  localparam logic [AW-1:0] LP_ROW     = AW'(W);
  localparam logic [AW-1:0] LP_OUT_ROW = AW'(W / 2);
  localparam logic [AW-1:0] LP_ONE     = AW'(1);

  logic [2:0]           r_state;
  logic [AW-1:0]        r_pr;
  logic [AW-1:0]        r_pc;
  logic signed [DW-1:0] r_max;
  logic                 r_rd_en;
  logic [AW-1:0]        r_rd_addr;
  logic                 r_wr_en;
  logic [AW-1:0]        r_wr_addr;
  logic [DW-1:0]        r_wr_data;
  logic                 r_busy;
  logic                 r_done;

  logic [2:0]           w_state_n;
  logic [AW-1:0]        w_pr_n;
  logic [AW-1:0]        w_pc_n;
  logic [AW-1:0]        w_base_n;
  logic [AW-1:0]        w_rd_addr_n;
  logic                 w_rd_en_n;
  logic                 w_last_pc;
  logic                 w_last_px;
  logic signed [DW-1:0] w_rd_s;
  logic signed [DW-1:0] w_max_upd;
  logic [DW-1:0]        w_wr_data_n;

  assign w_last_pc = (r_pc == LP_PC_LAST);
  assign w_last_px = w_last_pc && (r_pr == LP_PR_LAST);
  assign w_rd_s    = signed'(i_rd_data);
  assign w_max_upd = (w_rd_s > r_max) ? w_rd_s : r_max;

  always_comb begin
    w_state_n = r_state;
    w_pr_n    = r_pr;
    w_pc_n    = r_pc;
    case (r_state)
      S_IDLE: if (i_start) w_state_n = S_R0;
      S_R0:   w_state_n = S_R1;
      S_R1:   w_state_n = S_R2;
      S_R2:   w_state_n = S_R3;
      S_R3:   w_state_n = S_LAST;
      S_LAST: w_state_n = S_WR;
      S_WR: begin
        if (w_last_px) begin
          w_state_n = S_DONE;
          w_pr_n    = '0;
          w_pc_n    = '0;
        end else begin
          w_state_n = S_R0;
          if (w_last_pc) begin
            w_pc_n = '0;
            w_pr_n = r_pr + LP_ONE;
          end else begin
            w_pc_n = r_pc + LP_ONE;
          end
        end
      end
      S_DONE: begin
        w_state_n = S_IDLE;
        w_pr_n    = '0;
        w_pc_n    = '0;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Read address is registered, so it is derived from the counters of the state being entered.
  always_comb begin
    w_base_n    = LP_ROW2 * w_pr_n + {w_pc_n[AW-2:0], 1'b0};
    w_rd_en_n   = 1'b1;
    w_rd_addr_n = '0;
    case (w_state_n)
      S_R0:    w_rd_addr_n = w_base_n;
      S_R1:    w_rd_addr_n = w_base_n + LP_ONE;
      S_R2:    w_rd_addr_n = w_base_n + LP_ROW;
      S_R3:    w_rd_addr_n = w_base_n + LP_ROW + LP_ONE;
      default: w_rd_en_n   = 1'b0;
    endcase
  end

`ifdef POOL_RELU_EN
  assign w_wr_data_n = w_max_upd[DW-1] ? '0 : w_max_upd;
`else
  assign w_wr_data_n = w_max_upd;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_pr      <= '0;
      r_pc      <= '0;
      r_max     <= '0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_pr      <= w_pr_n;
      r_pc      <= w_pc_n;
      r_rd_en   <= w_rd_en_n;
      r_rd_addr <= w_rd_addr_n;
      r_busy    <= (w_state_n != S_IDLE);
      r_done    <= (w_state_n == S_DONE);
      r_wr_en   <= (r_state == S_LAST);
      r_wr_addr <= (r_state == S_LAST) ? (LP_OUT_ROW * r_pr + r_pc) : '0;
      r_wr_data <= (r_state == S_LAST) ? w_wr_data_n : '0;
      // rd_data lags rd_en by one cycle: R1 sees the R0 pixel, LAST sees the R3 pixel.
      case (r_state)
        S_R1:                 r_max <= w_rd_s;
        S_R2, S_R3, S_LAST:   r_max <= w_max_upd;
        S_DONE:               r_max <= '0;
        default:              r_max <= r_max;
      endcase
    end
  end

  assign o_rd_en   = r_rd_en;
  assign o_rd_addr = r_rd_addr;
  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;
  assign o_busy    = r_busy;
  assign o_done    = r_done;

endmodule

// File: tb/tb_pool_sequencer.sv
// Bench for pool_sequencer: 4x4, 5x5 and 28x28 instances, each with its own register-file model.
// Expected write-back is computed from a plain max-pool over the loaded image.
module tb_pool_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A: 4x4 ----------------
  logic       a_rst = 1'b1, a_start = 1'b0, a_load = 1'b0, a_clr = 1'b0;
  logic       a_rd_en, a_wr_en, a_busy, a_done;
  logic [3:0] a_rd_addr, a_wr_addr;
  logic [7:0] a_rd_data = '0, a_wr_data;
  logic [7:0] a_mem [16];
  logic [7:0] a_init [16];
  int a_wa [256]; logic [7:0] a_wd [256];
  int a_wcnt, a_dcnt, a_dcyc, a_r0cyc, a_r0addr, a_both;
  bit a_seen [16];

  pool_sequencer #(.H(4), .W(4), .DW(8), .AW(4)) u_a (
    .i_clk(clk), .i_rst(a_rst), .i_start(a_start),
    .o_rd_en(a_rd_en), .o_rd_addr(a_rd_addr), .i_rd_data(a_rd_data),
    .o_wr_en(a_wr_en), .o_wr_addr(a_wr_addr), .o_wr_data(a_wr_data),
    .o_busy(a_busy), .o_done(a_done));

  always @(posedge clk) begin
    if (a_load) a_mem <= a_init;
    else begin
      if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];
      if (a_wr_en) a_mem[a_wr_addr] <= a_wr_data;
    end
  end

  always @(negedge clk) begin
    if (a_clr) begin
      a_wcnt = 0; a_dcnt = 0; a_both = 0; a_r0cyc = -1; a_dcyc = -1; a_r0addr = -1;
      foreach (a_seen[i]) a_seen[i] = 1'b0;
    end else begin
      if (a_wr_en && a_wcnt < 256) begin a_wa[a_wcnt] = int'(a_wr_addr); a_wd[a_wcnt] = a_wr_data; a_wcnt++; end
      if (a_done) begin a_dcnt++; a_dcyc = cyc; end
      if (a_rd_en && a_wr_en) a_both++;
      if (a_rd_en) begin
        if (a_r0cyc < 0) begin a_r0cyc = cyc; a_r0addr = int'(a_rd_addr); end
        a_seen[a_rd_addr] = 1'b1;
      end
    end
  end

  // ---------------- instance B: 5x5 ----------------
  logic       b_rst = 1'b1, b_start = 1'b0, b_load = 1'b0, b_clr = 1'b0;
  logic       b_rd_en, b_wr_en, b_busy, b_done;
  logic [4:0] b_rd_addr, b_wr_addr;
  logic [7:0] b_rd_data = '0, b_wr_data;
  logic [7:0] b_mem [32];
  logic [7:0] b_init [32];
  int b_wa [256]; logic [7:0] b_wd [256];
  int b_wcnt, b_dcnt, b_dcyc, b_r0cyc;
  bit b_seen [32];

  pool_sequencer #(.H(5), .W(5), .DW(8), .AW(5)) u_b (
    .i_clk(clk), .i_rst(b_rst), .i_start(b_start),
    .o_rd_en(b_rd_en), .o_rd_addr(b_rd_addr), .i_rd_data(b_rd_data),
    .o_wr_en(b_wr_en), .o_wr_addr(b_wr_addr), .o_wr_data(b_wr_data),
    .o_busy(b_busy), .o_done(b_done));

  always @(posedge clk) begin
    if (b_load) b_mem <= b_init;
    else begin
      if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];
      if (b_wr_en) b_mem[b_wr_addr] <= b_wr_data;
    end
  end

  always @(negedge clk) begin
    if (b_clr) begin
      b_wcnt = 0; b_dcnt = 0; b_r0cyc = -1; b_dcyc = -1;
      foreach (b_seen[i]) b_seen[i] = 1'b0;
    end else begin
      if (b_wr_en && b_wcnt < 256) begin b_wa[b_wcnt] = int'(b_wr_addr); b_wd[b_wcnt] = b_wr_data; b_wcnt++; end
      if (b_done) begin b_dcnt++; b_dcyc = cyc; end
      if (b_rd_en) begin
        if (b_r0cyc < 0) b_r0cyc = cyc;
        b_seen[b_rd_addr] = 1'b1;
      end
    end
  end

  // ---------------- instance C: 28x28 ----------------
  logic       c_rst = 1'b1, c_start = 1'b0, c_load = 1'b0, c_clr = 1'b0;
  logic       c_rd_en, c_wr_en, c_busy, c_done;
  logic [9:0] c_rd_addr, c_wr_addr;
  logic [7:0] c_rd_data = '0, c_wr_data;
  logic [7:0] c_mem [1024];
  logic [7:0] c_init [1024];
  int c_wa [256]; logic [7:0] c_wd [256];
  int c_wcnt, c_dcnt, c_dcyc, c_r0cyc, c_both;

  pool_sequencer #(.H(28), .W(28), .DW(8), .AW(10)) u_c (
    .i_clk(clk), .i_rst(c_rst), .i_start(c_start),
    .o_rd_en(c_rd_en), .o_rd_addr(c_rd_addr), .i_rd_data(c_rd_data),
    .o_wr_en(c_wr_en), .o_wr_addr(c_wr_addr), .o_wr_data(c_wr_data),
    .o_busy(c_busy), .o_done(c_done));

  always @(posedge clk) begin
    if (c_load) c_mem <= c_init;
    else begin
      if (c_rd_en) c_rd_data <= c_mem[c_rd_addr];
      if (c_wr_en) c_mem[c_wr_addr] <= c_wr_data;
    end
  end

  always @(negedge clk) begin
    if (c_clr) begin
      c_wcnt = 0; c_dcnt = 0; c_both = 0; c_r0cyc = -1; c_dcyc = -1;
    end else begin
      if (c_wr_en && c_wcnt < 256) begin c_wa[c_wcnt] = int'(c_wr_addr); c_wd[c_wcnt] = c_wr_data; c_wcnt++; end
      if (c_done) begin c_dcnt++; c_dcyc = cyc; end
      if (c_rd_en && c_wr_en) c_both++;
      if (c_rd_en && c_r0cyc < 0) c_r0cyc = cyc;
    end
  end

  // ---------------- reference helpers ----------------
  function automatic logic [7:0] relu(input logic [7:0] v);
`ifdef POOL_RELU_EN
    return v[7] ? 8'h00 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [7:0] smax4(input logic [7:0] p, q, r, s);
    logic [7:0] m;
    m = p;
    if ($signed(q) > $signed(m)) m = q;
    if ($signed(r) > $signed(m)) m = r;
    if ($signed(s) > $signed(m)) m = s;
    return m;
  endfunction

  // ---------------- drivers ----------------
  task automatic a_prep();
    @(negedge clk); #1 a_load = 1'b1; a_clr = 1'b1;
    @(negedge clk); #1 a_load = 1'b0; a_clr = 1'b0;
  endtask

  task automatic a_kick();
    @(negedge clk); #1 a_start = 1'b1;
    @(negedge clk); #1 a_start = 1'b0;
  endtask

  task automatic a_wait_done(input int lim, input string nm);
    bit ok = 1'b0;
    repeat (lim) begin
      @(negedge clk); #1;
      if (a_done) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_timeout: done not seen, required within %0d cycles", nm, lim); end
  endtask

  task automatic a_check_4x4(input string nm);
    for (int pr = 0; pr < 2; pr++)
      for (int pc = 0; pc < 2; pc++) begin
        int b, k;
        logic [7:0] e;
        b = 8 * pr + 2 * pc;
        k = 2 * pr + pc;
        e = relu(smax4(a_init[b], a_init[b+1], a_init[b+4], a_init[b+5]));
        checks++;
        if (a_wcnt <= k || a_wa[k] !== k || a_wd[k] !== e) begin
          errors++;
          $display("FAIL %s_wr%0d: got addr=%0d data=%0d, required addr=%0d data=%0d",
                   nm, k, a_wa[k], $signed(a_wd[k]), k, $signed(e));
        end
      end
    checks++;
    if (a_wcnt !== 4) begin errors++; $display("FAIL %s_wcnt: got %0d, required 4", nm, a_wcnt); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({a_rd_en, a_wr_en, a_busy, a_done, a_rd_addr, a_wr_addr, a_wr_data} !== '0) begin
      errors++; $display("FAIL reset_a: outputs not all zero under reset");
    end
    checks++;
    if ({b_rd_en, b_wr_en, b_busy, b_done, c_rd_en, c_wr_en, c_busy, c_done} !== '0) begin
      errors++; $display("FAIL reset_bc: control outputs not zero under reset");
    end
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (a_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b, required 0", a_busy); end
  endtask

  task automatic test_ramp_4x4();
    for (int i = 0; i < 16; i++) a_init[i] = 8'(i);
    a_prep();
    a_kick();
    a_wait_done(100, "ramp");
    @(negedge clk); #1;
    checks++;
    if (a_busy !== 1'b0) begin errors++; $display("FAIL ramp_busy_after_done: got %0b, required 0", a_busy); end
    a_check_4x4("ramp");
    checks++;
    if (a_dcyc - a_r0cyc + 1 !== 25) begin
      errors++; $display("FAIL ramp_latency: got %0d cycles, required 25", a_dcyc - a_r0cyc + 1);
    end
    checks++;
    if (a_both !== 0) begin errors++; $display("FAIL ramp_rd_wr_overlap: got %0d, required 0", a_both); end
  endtask

  task automatic test_negative();
    foreach (a_init[i]) a_init[i] = 8'h00;
    a_init[0] = 8'hF8; a_init[1] = 8'hFD; a_init[4] = 8'hFB; a_init[5] = 8'hFE;
    a_prep();
    a_kick();
    a_wait_done(100, "neg");
    a_check_4x4("neg");
  endtask

  task automatic test_odd_5x5();
    int exp_d [4] = '{6, 8, 16, 18};
    int skip [9] = '{4, 9, 14, 19, 20, 21, 22, 23, 24};
    bit ok = 1'b0;
    for (int i = 0; i < 32; i++) b_init[i] = 8'(i);
    @(negedge clk); #1 b_load = 1'b1; b_clr = 1'b1;
    @(negedge clk); #1 b_load = 1'b0; b_clr = 1'b0; b_start = 1'b1;
    @(negedge clk); #1 b_start = 1'b0;
    repeat (100) begin
      @(negedge clk); #1;
      if (b_done) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL odd_timeout: done not seen, required within 100 cycles"); end
    checks++;
    if (b_wcnt !== 4) begin errors++; $display("FAIL odd_wcnt: got %0d, required 4", b_wcnt); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (b_wa[k] !== k || b_wd[k] !== 8'(exp_d[k])) begin
        errors++; $display("FAIL odd_wr%0d: got addr=%0d data=%0d, required addr=%0d data=%0d",
                           k, b_wa[k], b_wd[k], k, exp_d[k]);
      end
    end
    foreach (skip[i]) begin
      checks++;
      if (b_seen[skip[i]] !== 1'b0) begin errors++; $display("FAIL odd_unread%0d: got read, required never read", skip[i]); end
    end
    checks++;
    if (b_dcyc - b_r0cyc + 1 !== 25) begin
      errors++; $display("FAIL odd_latency: got %0d cycles, required 25", b_dcyc - b_r0cyc + 1);
    end
  endtask

  task automatic test_start_ignored();
    bit f2 = 1'b0, fw = 1'b0;
    for (int i = 0; i < 16; i++) a_init[i] = 8'($urandom);
    a_prep();
    a_kick();
    repeat (20) begin
      if (a_rd_en && a_rd_addr == 4'd4) begin f2 = 1'b1; break; end
      @(negedge clk); #1;
    end
    a_start = 1'b1; @(negedge clk); #1 a_start = 1'b0;
    repeat (20) begin
      if (a_wr_en) begin fw = 1'b1; break; end
      @(negedge clk); #1;
    end
    a_start = 1'b1; @(negedge clk); #1 a_start = 1'b0;
    checks++;
    if (!(f2 && fw)) begin errors++; $display("FAIL ign_find: got R2=%0b WR=%0b, required both found", f2, fw); end
    a_wait_done(100, "ign");
    repeat (10) @(negedge clk);
    #1;
    a_check_4x4("ign");
    checks++;
    if (a_dcnt !== 1 || a_busy !== 1'b0) begin
      errors++; $display("FAIL ign_done: got dcnt=%0d busy=%0b, required dcnt=1 busy=0", a_dcnt, a_busy);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    for (int i = 0; i < 16; i++) a_init[i] = 8'($urandom);
    a_prep();
    a_kick();
    repeat (30) begin
      if (a_wr_en && a_wr_addr == 4'd1) begin found = 1'b1; break; end
      @(negedge clk); #1;
    end
    a_rst = 1'b1; @(negedge clk); #1 a_rst = 1'b0;
    checks++;
    if (!found || a_busy !== 1'b0 || a_wr_en !== 1'b0 || a_rd_en !== 1'b0 || a_done !== 1'b0) begin
      errors++; $display("FAIL rstmid_state: got found=%0b busy=%0b wr_en=%0b rd_en=%0b done=%0b, required 1 0 0 0 0",
                         found, a_busy, a_wr_en, a_rd_en, a_done);
    end
    a_prep();
    a_kick();
    checks++;
    if (a_rd_en !== 1'b1 || a_rd_addr !== 4'd0) begin
      errors++; $display("FAIL rstmid_restart: got rd_en=%0b rd_addr=%0d, required 1 0", a_rd_en, a_rd_addr);
    end
    a_wait_done(100, "rstmid");
    a_check_4x4("rstmid");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 16; i++) a_init[i] = 8'($urandom);
      a_prep();
      a_kick();
      a_wait_done(100, "b2b");
      a_check_4x4("b2b");
    end
  endtask

  task automatic test_full_28x28();
    bit ok = 1'b0;
    for (int i = 0; i < 1024; i++) c_init[i] = 8'($urandom);
    @(negedge clk); #1 c_load = 1'b1; c_clr = 1'b1;
    @(negedge clk); #1 c_load = 1'b0; c_clr = 1'b0; c_start = 1'b1;
    @(negedge clk); #1 c_start = 1'b0;
    repeat (1400) begin
      @(negedge clk); #1;
      if (c_done) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL full_timeout: done not seen, required within 1400 cycles"); end
    checks++;
    if (c_wcnt !== 196) begin errors++; $display("FAIL full_wcnt: got %0d, required 196", c_wcnt); end
    for (int pr = 0; pr < 14; pr++)
      for (int pc = 0; pc < 14; pc++) begin
        int b, k;
        logic [7:0] e;
        b = 56 * pr + 2 * pc;
        k = 14 * pr + pc;
        e = relu(smax4(c_init[b], c_init[b+1], c_init[b+28], c_init[b+29]));
        checks++;
        if (c_wa[k] !== k || c_wd[k] !== e) begin
          errors++; $display("FAIL full_wr%0d: got addr=%0d data=%0d, required addr=%0d data=%0d",
                             k, c_wa[k], $signed(c_wd[k]), k, $signed(e));
        end
      end
    checks++;
    if (c_dcyc - c_r0cyc + 1 !== 1177) begin
      errors++; $display("FAIL full_latency: got %0d cycles, required 1177", c_dcyc - c_r0cyc + 1);
    end
    checks++;
    if (c_both !== 0 || c_dcnt !== 1) begin
      errors++; $display("FAIL full_misc: got overlap=%0d dcnt=%0d, required 0 1", c_both, c_dcnt);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_4x4();
    test_negative();
    test_odd_5x5();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_full_28x28();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
